// File: rtl/rr_pkg.sv
// Shared definitions for the round-robin client queue: client count, id width,
// default sizing and a one-hot test used to qualify arbiter grants.
package rr_pkg;

    localparam int unsigned NUM_CLIENTS = 4;
    localparam int unsigned ID_W        = 2;
    localparam int unsigned DEF_DW      = 8;
    localparam int unsigned DEF_DEPTH   = 4;

    typedef logic [NUM_CLIENTS-1:0] client_vec_t;

    // True when exactly one bit of v is set.
    function automatic logic is_onehot(input client_vec_t v);
        return (v != '0) && ((v & (v - client_vec_t'(1))) == '0);
    endfunction

endpackage

// File: rtl/rr_sync_fifo.sv
// Single-clock FIFO with occupancy count; read data is the current head word.
// Pointers wrap naturally because DEPTH is a power of two.
module rr_sync_fifo #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] wr_data_i,
    output logic [DW-1:0] rd_data_o,
    output logic [CW-1:0] count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push_i) - CW'(pop_i);
        if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

endmodule

// File: rtl/rr_client_queue.sv
// Four per-client FIFOs feeding a round-robin arbiter; the granted head word is
// moved into a registered valid/ready output stage. Bad grants raise a sticky flag.
module rr_client_queue
    import rr_pkg::*;
#(
    parameter int unsigned DW    = DEF_DW,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [ID_W-1:0]        in_id,
    input  logic [DW-1:0]          in_data,
    output logic                   in_ready,
    output logic [NUM_CLIENTS-1:0] req,
    input  logic [NUM_CLIENTS-1:0] grant,
    output logic                   out_valid,
    output logic [DW-1:0]          out_data,
    output logic [ID_W-1:0]        out_id,
    input  logic                   out_ready,
    output logic                   grant_err
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [NUM_CLIENTS-1:0] push;
    logic [NUM_CLIENTS-1:0] pop;
    logic [NUM_CLIENTS-1:0] nonempty;
    logic [DW-1:0]          rd_data [NUM_CLIENTS];
    logic [CW-1:0]          count   [NUM_CLIENTS];

    logic            grant_onehot;
    logic            grant_multi;
    logic            grant_empty;
    logic            out_free;

    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_data_q,  out_data_d;
    logic [ID_W-1:0] out_id_q,    out_id_d;
    logic            grant_err_q, grant_err_d;

    assign in_ready     = (count[in_id] != CW'(DEPTH));
    assign out_free     = !out_valid_q || out_ready;
    assign grant_onehot = is_onehot(grant);

    for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_client
        assign push[i]     = in_valid && in_ready && (in_id == ID_W'(i));
        assign nonempty[i] = (count[i] != '0);
        assign pop[i]      = grant[i] && grant_onehot && nonempty[i] && out_free;
        // Request reflects occupancy after this cycle's push/pop, so a registered
        // grant never lands on a FIFO its previous grant just emptied.
        assign req[i]      = !rst && ((count[i] + CW'(push[i]) - CW'(pop[i])) != '0);

        rr_sync_fifo #(
            .DW    (DW),
            .DEPTH (DEPTH),
            .CW    (CW)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push_i    (push[i]),
            .pop_i     (pop[i]),
            .wr_data_i (in_data),
            .rd_data_o (rd_data[i]),
            .count_o   (count[i])
        );
    end

    assign grant_multi = (grant != '0) && !grant_onehot;
    assign grant_empty = grant_onehot && ((grant & nonempty) == '0);

    // Output stage: load on pop, empty when free with nothing popped, else hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        grant_err_d = grant_err_q || grant_multi || grant_empty;
        if (out_free) begin
            out_valid_d = 1'b0;
            for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
                if (pop[i]) begin
                    out_valid_d = 1'b1;
                    out_data_d  = rd_data[i];
                    out_id_d    = ID_W'(i);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            grant_err_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            grant_err_q <= grant_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign grant_err = grant_err_q;

endmodule

// File: tb/tb_rr_client_queue.sv
// Bench for rr_client_queue: behavioural round-robin arbiter in the loop, a
// per-client scoreboard checked by an output monitor, and scenario tasks.
module tb_rr_client_queue;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [1:0] in_id;
    logic [7:0] in_data;
    logic       in_ready;
    logic [3:0] req;
    logic [3:0] grant;
    logic       out_valid;
    logic [7:0] out_data;
    logic [1:0] out_id;
    logic       out_ready;
    logic       grant_err;

    logic [3:0] arb_grant;
    logic [3:0] force_grant;
    logic       arb_en;
    logic       force_en;
    int         arb_last;

    logic [7:0] exp_q [4][$];
    int         exp_id_q [$];
    int         xfer_cnt = 0;
    int         vectors = 0;
    int         miscompares = 0;

    rr_client_queue #(.DW(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_id     (in_id),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .req       (req),
        .grant     (grant),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready),
        .grant_err (grant_err)
    );

    always #5 clk = ~clk;

    assign grant = force_en ? force_grant : arb_grant;

    // Registered round-robin arbiter model, search starts after the last winner.
    always @(posedge clk) begin
        if (rst || !arb_en) begin
            arb_grant <= 4'b0000;
            if (rst) arb_last <= 3;
        end else begin
            logic [3:0] g;
            int nl;
            g  = 4'b0000;
            nl = arb_last;
            for (int k = 1; k <= 4; k++) begin
                int idx;
                idx = (arb_last + k) % 4;
                if (g == 4'b0000 && req[idx]) begin
                    g[idx] = 1'b1;
                    nl = idx;
                end
            end
            arb_grant <= g;
            arb_last  <= nl;
        end
    end

    // Scoreboard: every accepted output word must match the head of its client queue.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            xfer_cnt++;
            vectors++;
            if (exp_q[out_id].size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected: got id=%0d data=%h, required no output", out_id, out_data);
            end else begin
                logic [7:0] e;
                e = exp_q[out_id].pop_front();
                if (out_data !== e) begin
                    miscompares++;
                    $display("FAIL sb_data id=%0d: got %h, required %h", out_id, out_data, e);
                end
            end
            if (exp_id_q.size() != 0) begin
                int ei;
                ei = exp_id_q.pop_front();
                vectors++;
                if (int'(out_id) !== ei) begin
                    miscompares++;
                    $display("FAIL sb_order: got id %0d, required id %0d", out_id, ei);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sb();
        for (int i = 0; i < 4; i++) exp_q[i].delete();
        exp_id_q.delete();
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        arb_en = 1'b0;
        force_en = 1'b0;
        force_grant = 4'b0000;
        clear_sb();
        repeat (cycles) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic push(input int id, input logic [7:0] d);
        in_valid = 1'b1;
        in_id = 2'(id);
        in_data = d;
        @(negedge clk);
        if (in_ready) exp_q[id].push_back(d);
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(2);
        @(negedge clk);
        vectors++; if (req !== 4'b0000) begin miscompares++; $display("FAIL reset_req: got %b, required 0000", req); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        vectors++; if (grant_err !== 1'b0) begin miscompares++; $display("FAIL reset_grant_err: got %b, required 0", grant_err); end
        for (int i = 0; i < 4; i++) begin
            in_id = 2'(i);
            #1;
            vectors++;
            if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready id=%0d: got %b, required 1", i, in_ready); end
        end
        step();
    endtask

    task automatic test_single();
        do_reset(1);
        arb_en = 1'b1;
        in_valid = 1'b1; in_id = 2'd2; in_data = 8'hA5;
        @(negedge clk);
        vectors++; if (req !== 4'b0100) begin miscompares++; $display("FAIL single_req_push: got %b, required 0100", req); end
        if (in_ready) exp_q[2].push_back(8'hA5);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        vectors++; if (req !== 4'b0000) begin miscompares++; $display("FAIL single_req_granted: got %b, required 0000", req); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_early_valid: got %b, required 0", out_valid); end
        step();
        @(negedge clk);
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %b, required 1", out_valid); end
        vectors++; if (out_id !== 2'd2) begin miscompares++; $display("FAIL single_id: got %0d, required 2", out_id); end
        vectors++; if (out_data !== 8'hA5) begin miscompares++; $display("FAIL single_data: got %h, required a5", out_data); end
        step();
        @(negedge clk);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_valid_drop: got %b, required 0", out_valid); end
        vectors++; if (grant_err !== 1'b0) begin miscompares++; $display("FAIL single_grant_err: got %b, required 0", grant_err); end
        step();
    endtask

    task automatic test_rr_drain();
        int run = 0;
        int maxrun = 0;
        int x0;
        do_reset(1);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) begin
                push(i, 8'(16 * (r + 1) + i));
                exp_id_q.push_back(i);
            end
        end
        x0 = xfer_cnt;
        arb_en = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid) begin
                run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
        end
        vectors++; if (maxrun !== 8) begin miscompares++; $display("FAIL rr_consecutive: got %0d, required 8", maxrun); end
        vectors++; if (xfer_cnt - x0 !== 8) begin miscompares++; $display("FAIL rr_count: got %0d, required 8", xfer_cnt - x0); end
        vectors++; if (exp_id_q.size() !== 0) begin miscompares++; $display("FAIL rr_leftover: got %0d, required 0", exp_id_q.size()); end
        step();
    endtask

    task automatic test_full_backpressure();
        bit found = 0;
        int x0;
        do_reset(1);
        for (int k = 0; k < 4; k++) push(1, 8'(8'h31 + k));
        in_valid = 1'b1; in_id = 2'd1; in_data = 8'h35;
        @(negedge clk);
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL full_in_ready: got %b, required 0", in_ready); end
        vectors++; if (req !== 4'b0010) begin miscompares++; $display("FAIL full_req: got %b, required 0010", req); end
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        arb_en = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid) begin found = 1; break; end
        end
        vectors++; if (!found) begin miscompares++; $display("FAIL bp_wait_valid: got timeout, required out_valid within 10 cycles"); end
        for (int h = 0; h < 3; h++) begin
            step();
            @(negedge clk);
            vectors++; if (out_data !== 8'h31 || out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_hold cycle %0d: got v=%b d=%h, required v=1 d=31", h, out_valid, out_data); end
            vectors++; if (req[1] !== 1'b1) begin miscompares++; $display("FAIL bp_req cycle %0d: got %b, required 1", h, req[1]); end
        end
        step();
        x0 = xfer_cnt;
        out_ready = 1'b1;
        repeat (12) @(negedge clk);
        vectors++; if (xfer_cnt - x0 !== 4) begin miscompares++; $display("FAIL bp_count: got %0d, required 4", xfer_cnt - x0); end
        vectors++; if (exp_q[1].size() !== 0) begin miscompares++; $display("FAIL bp_leftover: got %0d, required 0", exp_q[1].size()); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_idle: got %b, required 0", out_valid); end
        vectors++; if (grant_err !== 1'b0) begin miscompares++; $display("FAIL bp_grant_err: got %b, required 0", grant_err); end
        step();
    endtask

    task automatic test_reset_midop();
        do_reset(1);
        push(0, 8'h77);
        push(2, 8'h78);
        out_ready = 1'b0;
        arb_en = 1'b1;
        repeat (3) step();
        @(negedge clk);
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL midop_pending: got %b, required 1", out_valid); end
        step();
        rst = 1'b1;
        clear_sb();
        @(negedge clk);
        vectors++; if (req !== 4'b0000) begin miscompares++; $display("FAIL midop_req_in_rst: got %b, required 0000", req); end
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midop_out_valid: got %b, required 0", out_valid); end
        vectors++; if (req !== 4'b0000) begin miscompares++; $display("FAIL midop_req: got %b, required 0000", req); end
        step();
    endtask

    task automatic test_simul_full();
        do_reset(1);
        force_en = 1'b1;
        for (int k = 0; k < 4; k++) push(3, 8'(8'h40 + k));
        force_grant = 4'b1000;
        in_valid = 1'b1; in_id = 2'd1; in_data = 8'h50;
        @(negedge clk);
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL simul_in_ready_c1: got %b, required 1", in_ready); end
        vectors++; if (req !== 4'b1010) begin miscompares++; $display("FAIL simul_req: got %b, required 1010", req); end
        if (in_ready) exp_q[1].push_back(8'h50);
        step();
        // Client 3 now holds 3; push and pop it together for 2*DEPTH cycles.
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1; in_id = 2'd3; in_data = 8'(8'h60 + k);
            @(negedge clk);
            vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL simul_in_ready_c3 op %0d: got %b, required 1", k, in_ready); end
            vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL simul_stream op %0d: got %b, required 1", k, out_valid); end
            if (in_ready) exp_q[3].push_back(8'(8'h60 + k));
            step();
        end
        in_valid = 1'b0;
        repeat (3) step();
        force_grant = 4'b0010;
        step();
        force_grant = 4'b0000;
        repeat (3) @(negedge clk);
        vectors++; if (exp_q[3].size() !== 0 || exp_q[1].size() !== 0) begin miscompares++; $display("FAIL simul_leftover: got c3=%0d c1=%0d, required 0 0", exp_q[3].size(), exp_q[1].size()); end
        vectors++; if (req !== 4'b0000) begin miscompares++; $display("FAIL simul_req_end: got %b, required 0000", req); end
        vectors++; if (grant_err !== 1'b0) begin miscompares++; $display("FAIL simul_grant_err: got %b, required 0", grant_err); end
        step();
    endtask

    task automatic test_illegal_grant();
        do_reset(1);
        force_en = 1'b1;
        push(0, 8'h81);
        push(2, 8'h82);
        force_grant = 4'b0101;
        @(negedge clk);
        vectors++; if (req !== 4'b0101) begin miscompares++; $display("FAIL multi_no_pop_req: got %b, required 0101", req); end
        step();
        force_grant = 4'b0000;
        @(negedge clk);
        vectors++; if (grant_err !== 1'b1) begin miscompares++; $display("FAIL multi_grant_err: got %b, required 1", grant_err); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL multi_out_valid: got %b, required 0", out_valid); end
        step();
        do_reset(1);
        @(negedge clk);
        vectors++; if (grant_err !== 1'b0) begin miscompares++; $display("FAIL err_clear1: got %b, required 0", grant_err); end
        step();
        force_en = 1'b1;
        push(1, 8'h83);
        force_grant = 4'b0001;
        step();
        force_grant = 4'b0000;
        @(negedge clk);
        vectors++; if (grant_err !== 1'b1) begin miscompares++; $display("FAIL empty_grant_err: got %b, required 1", grant_err); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL empty_out_valid: got %b, required 0", out_valid); end
        vectors++; if (req !== 4'b0010) begin miscompares++; $display("FAIL empty_req: got %b, required 0010", req); end
        repeat (3) @(negedge clk);
        vectors++; if (grant_err !== 1'b1) begin miscompares++; $display("FAIL err_sticky: got %b, required 1", grant_err); end
        step();
        do_reset(1);
        @(negedge clk);
        vectors++; if (grant_err !== 1'b0) begin miscompares++; $display("FAIL err_clear2: got %b, required 0", grant_err); end
        step();
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_id = 2'd0;
        in_data = 8'h00;
        out_ready = 1'b1;
        arb_en = 1'b0;
        force_en = 1'b0;
        force_grant = 4'b0000;
        test_reset();
        test_single();
        test_rr_drain();
        test_full_backpressure();
        test_reset_midop();
        test_simul_full();
        test_illegal_grant();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

endmodule
